// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM states, slave word
// addresses and the expected image identity for the current system build.
package sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      CHECK,
      DONE
   } sysid_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // Must track the sysid slave contents of the matching FPGA build.
   localparam logic [31:0] SYSID_EXPECTED_ID = 32'd0;
   localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1524000766;

endpackage

// File: rtl/sysid_checker_avm_read_port.sv
// Single-word Avalon-MM read engine: holds the request through waitrequest,
// counts the fixed read latency and aborts after too many stall cycles.
module avm_read_port
   import sysid_pkg::*;
#(
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT      = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        addr,
   output logic        rvalid,
   output logic        accept,
   output logic        tout,
   output logic [31:0] rdata,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);
   localparam logic [2:0]  LAT_INIT   = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   logic        lat_active;
   logic [2:0]  lat_cnt;
   logic [15:0] wait_cnt;

   assign accept = avm_read & ~avm_waitrequest;
   assign tout   = avm_read & avm_waitrequest & (wait_cnt == WAIT_LIMIT);
   assign rdata  = avm_readdata;

   // Zero latency: data is valid alongside the accept; otherwise when the countdown expires.
   assign rvalid = (READ_LATENCY == 0) ? accept : (lat_active && (lat_cnt == 3'd0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         avm_read    <= 1'b0;
         avm_address <= SYSID_ADDR_ID;
         wait_cnt    <= 16'd0;
         lat_active  <= 1'b0;
         lat_cnt     <= 3'd0;
      end else if (req) begin
         avm_read    <= 1'b1;
         avm_address <= addr;
         wait_cnt    <= 16'd0;
         lat_active  <= 1'b0;
      end else if (avm_read) begin
         if (avm_waitrequest) begin
            if (tout) begin
               avm_read <= 1'b0;
               wait_cnt <= 16'd0;
            end else begin
               wait_cnt <= wait_cnt + 16'd1;
            end
         end else begin
            avm_read   <= 1'b0;
            wait_cnt   <= 16'd0;
            lat_active <= (READ_LATENCY > 0);
            lat_cnt    <= LAT_INIT;
         end
      end else if (lat_active) begin
         if (lat_cnt == 3'd0) begin
            lat_active <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 3'd1;
         end
      end
   end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time image check: reads the sysid ID and timestamp words over Avalon-MM
// and reports whether they match the values this control logic was built for.
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID  = SYSID_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS  = SYSID_EXPECTED_TS,
   parameter int          READ_LATENCY = 0,
   parameter int          TIMEOUT      = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   sysid_state_t state;

   logic        rd_req;
   logic        rd_addr;
   logic        rd_valid;
   logic        rd_accept;
   logic        rd_tout;
   logic [31:0] rd_data;

   avm_read_port #(
      .READ_LATENCY (READ_LATENCY),
      .TIMEOUT      (TIMEOUT)
   ) u_read_port (
      .clock           (clock),
      .reset           (reset),
      .req             (rd_req),
      .addr            (rd_addr),
      .rvalid          (rd_valid),
      .accept          (rd_accept),
      .tout            (rd_tout),
      .rdata           (rd_data),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata)
   );

   // The timestamp read is issued in the same cycle the ID word lands, so the
   // two reads go out back to back when the slave never stalls.
   always_comb begin
      rd_req  = 1'b0;
      rd_addr = SYSID_ADDR_ID;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               rd_req  = 1'b1;
               rd_addr = SYSID_ADDR_ID;
            end
         end
         RD_ID, LAT_ID: begin
            if (rd_valid) begin
               rd_req  = 1'b1;
               rd_addr = SYSID_ADDR_TS;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= 32'd0;
         ts_value    <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RD_ID;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  id_mismatch <= 1'b0;
                  ts_mismatch <= 1'b0;
                  timeout     <= 1'b0;
                  id_value    <= 32'd0;
                  ts_value    <= 32'd0;
               end else if (state == DONE) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= ~id_mismatch & ~ts_mismatch & ~timeout;
               end
            end
            RD_ID: begin
               if (rd_tout) begin
                  state   <= DONE;
                  timeout <= 1'b1;
               end else if (rd_valid) begin
                  id_value <= rd_data;
                  state    <= RD_TS;
               end else if (rd_accept) begin
                  state <= LAT_ID;
               end
            end
            LAT_ID: begin
               if (rd_valid) begin
                  id_value <= rd_data;
                  state    <= RD_TS;
               end
            end
            RD_TS: begin
               if (rd_tout) begin
                  state   <= DONE;
                  timeout <= 1'b1;
               end else if (rd_valid) begin
                  ts_value <= rd_data;
                  state    <= CHECK;
               end else if (rd_accept) begin
                  state <= LAT_TS;
               end
            end
            LAT_TS: begin
               if (rd_valid) begin
                  ts_value <= rd_data;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               id_mismatch <= (id_value != EXPECTED_ID);
               ts_mismatch <= (ts_value != EXPECTED_TS);
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
